par_frame_tx: RTL and testbench

//  Transmit side of the 8-lane even-parity codeword interface. Accepts 3-bit data

---
 rtl/par_frame_tx.sv | 97 +++++++++
 tb/tb_par_frame_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/par_frame_tx.sv
// par_frame_tx: encodes data words as even-parity codewords and packs NLANES
// of them into a frame. The first word lands in the top lane, the last in lane 0.
// An optional per-word bit flip lets the downstream lane checker be exercised.
module par_frame_tx #(
  parameter int unsigned DW     = 3,
  parameter int unsigned NLANES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          inj,
  input  logic [$clog2(DW+1)-1:0]       inj_bit,
  output logic [NLANES*(DW+1)-1:0]      frame,
  output logic                          frame_val,
  input  logic                          frame_rdy,
  output logic [NLANES-1:0]             err_mask,
  output logic [7:0]                    frame_cnt
);

  localparam int unsigned CW = DW + 1;
  localparam int unsigned IW = $clog2(NLANES);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;

  logic [CW-1:0]     codeword_c;
  logic [IW-1:0]     lane_c;
  logic [NLANES-1:0] mask_nxt_c;

  // Codeword with parity in the LSB, optionally corrupted, and its destination lane.
  always_comb begin
    codeword_c = {in_data, ^in_data} ^ (CW'(inj) << inj_bit);
    lane_c     = IW'(NLANES - 1) - idx;
  end

  // Injection mask: restart on the first word of a frame, then record each lane.
  always_comb begin
    mask_nxt_c         = (idx == '0) ? '0 : err_mask;
    mask_nxt_c[lane_c] = inj;
  end

  // Frame assembly FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      frame     <= '0;
      err_mask  <= '0;
      frame_val <= 1'b0;
      in_ready  <= 1'b1;
      frame_cnt <= 8'd0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            for (int k = 0; k < NLANES; k++) begin
              if (lane_c == IW'(k)) begin
                frame[k*CW +: CW] <= codeword_c;
              end
            end
            err_mask <= mask_nxt_c;
            if (idx == IW'(NLANES - 1)) begin
              state     <= HOLD;
              idx       <= '0;
              in_ready  <= 1'b0;
              frame_val <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (frame_rdy) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            frame_val <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state     <= FILL;
          idx       <= '0;
          in_ready  <= 1'b1;
          frame_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_frame_tx.sv
// Directed and randomized checks of the parity frame transmitter.
module tb_par_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        inj;
  logic [1:0]  inj_bit;
  logic [31:0] frame;
  logic        frame_val;
  logic        frame_rdy;
  logic [7:0]  err_mask;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  par_frame_tx #(.DW(3), .NLANES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inj       (inj),
    .inj_bit   (inj_bit),
    .frame     (frame),
    .frame_val (frame_val),
    .frame_rdy (frame_rdy),
    .err_mask  (err_mask),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] words;     // word 0 in bits [23:21]
    int          inj_word;  // -1: no injection
    logic [1:0]  inj_b;
    logic [31:0] exp_frame;
    logic [7:0]  exp_mask;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [2:0] d, input logic i, input logic [1:0] b);
    logic rdy;
    int   n;
    n = 0;
    in_data  = d;
    inj      = i;
    inj_bit  = b;
    in_valid = 1'b1;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, required 1", rdy, n);
    end
    in_valid = 1'b0;
    inj      = 1'b0;
  endtask

  task automatic release_frame();
    frame_rdy = 1'b1;
    tick();
    frame_rdy = 1'b0;
    in_valid  = 1'b0;
    exp_cnt   = (exp_cnt + 1) % 256;
    chk("release_val", 32'(frame_val), 32'd0);
    chk("release_rdy", 32'(in_ready), 32'd1);
    chk("release_cnt", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  task automatic run_vec(input vec_t v);
    logic [2:0] d;
    for (int w = 0; w < 8; w++) begin
      d = v.words[23-3*w -: 3];
      if (w == 7) chk("val_before_last", 32'(frame_val), 32'd0);
      send_word(d, (w == v.inj_word), v.inj_b);
    end
    chk("vec_frame", frame, v.exp_frame);
    chk("vec_mask", 32'(err_mask), 32'(v.exp_mask));
    chk("vec_val", 32'(frame_val), 32'd1);
    chk("vec_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] held_frame, exp_f;
    logic [7:0]  held_mask, exp_m;
    logic [3:0]  cw, lane;
    logic [2:0]  d;
    logic        wi;
    logic [1:0]  wb;
    int          bad, highs, par_bad;

    vecs[0] = '{24'h053977, -1, 2'd0, 32'h03569ACF, 8'h00};
    vecs[1] = '{24'h053977,  2, 2'd0, 32'h03469ACF, 8'h20};
    vecs[2] = '{24'hFAC688, -1, 2'd0, 32'hFCA96530, 8'h00};
    vecs[3] = '{24'hB6DB6D,  7, 2'd3, 32'hAAAAAAA2, 8'h01};
    vecs[4] = '{24'h6DB6DB,  0, 2'd2, 32'h26666666, 8'h80};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; inj = 1'b0; inj_bit = '0; frame_rdy = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_frame", frame, 32'h0);
    chk("rst_val", 32'(frame_val), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_mask", 32'(err_mask), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);

    // Table of directed frames, each released before the next.
    for (int t = 0; t < 5; t++) begin
      run_vec(vecs[t]);
      release_frame();
    end

    // Stalled downstream with a persistent source: nothing may move.
    run_vec(vecs[1]);
    held_frame = frame;
    held_mask  = err_mask;
    in_valid = 1'b1; in_data = 3'd7; inj = 1'b1; inj_bit = 2'd1;
    repeat (20) tick();
    chk("hold_frame", frame, 32'h03469ACF);
    chk("hold_mask", 32'(err_mask), 32'h20);
    chk("hold_val", 32'(frame_val), 32'd1);
    chk("hold_cnt", 32'(frame_cnt), 32'(exp_cnt));
    inj = 1'b0;
    release_frame();
    run_vec(vecs[2]);
    release_frame();

    // Reset in the middle of a frame.
    for (int w = 0; w < 5; w++) send_word(3'(w + 1), 1'b0, 2'd0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_frame", frame, 32'h0);
    chk("midrst_val", 32'(frame_val), 32'd0);
    chk("midrst_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_mask", 32'(err_mask), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    tick();
    run_vec(vecs[0]);
    release_frame();

    // Back-to-back streaming from a fresh reset: 256 frames, period 9.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_cnt = 0;
    in_valid = 1'b1; frame_rdy = 1'b1; inj = 1'b0;
    bad = 0; highs = 0;
    for (int i = 1; i <= 2304; i++) begin
      in_data = 3'(i - 1);
      tick();
      if (frame_val !== ((i % 9) == 8)) bad++;
      if (frame_val === 1'b1) highs++;
      if (i == 8) chk("stream_first_frame", frame, 32'h03569ACF);
      if (i == 2295) chk("stream_cnt_255", 32'(frame_cnt), 32'd255);
    end
    in_valid = 1'b0; frame_rdy = 1'b0;
    chk("stream_period_errs", 32'(bad), 32'd0);
    chk("stream_frames", 32'(highs), 32'd256);
    chk("stream_cnt_wrap", 32'(frame_cnt), 32'd0);
    chk("stream_end_val", 32'(frame_val), 32'd0);

    // Random gaps, injections and spurious strobes against a reference model.
    exp_cnt = 0;
    par_bad = 0;
    for (int f = 0; f < 300; f++) begin
      exp_f = '0;
      exp_m = '0;
      for (int w = 0; w < 8; w++) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid  = 1'b0;
          in_data   = 3'($urandom);
          frame_rdy = 1'($urandom);
          tick();
        end
        frame_rdy = 1'b0;
        d  = 3'($urandom);
        wi = ($urandom_range(0, 3) == 0);
        wb = 2'($urandom);
        cw = {d, ^d};
        if (wi) cw[wb] = ~cw[wb];
        exp_f[(7-w)*4 +: 4] = cw;
        exp_m[7-w] = wi;
        send_word(d, wi, wb);
      end
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b1;
        in_data  = 3'($urandom);
        tick();
      end
      chk("rand_frame", frame, exp_f);
      chk("rand_mask", 32'(err_mask), 32'(exp_m));
      for (int k = 0; k < 8; k++) begin
        lane = frame[k*4 +: 4];
        if (!exp_m[k] && (^lane)) par_bad++;
      end
      in_valid = 1'b1;
      release_frame();
    end
    chk("rand_parity_errs", 32'(par_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
